fifo_rd_arb: RTL and testbench
==============================

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, payload width per entry.
REQ-002 The block SHALL have parameter FLUX, default 2, number of fluxes (legal range 2..16).
REQ-003 The block SHALL have derived localparam TAG_WIDTH = $clog2(FLUX), the flux tag width.
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port fifo_empty  input  FLUX  per-flux empty flags from the shared multi-flux FIFO.
REQ-007 The block SHALL have port fifo_dout  input  TAG_WIDTH+DATA_WIDTH  FIFO read data {tag, data}, valid combinationally in the cycle fifo_read is asserted.
REQ-008 The block SHALL have port fifo_read  output  FLUX  one-hot read strobe to the FIFO.
REQ-009 The block SHALL have port flux_en  input  FLUX  per-flux arbitration enable mask.
REQ-010 The block SHALL have port m_valid  output  1  output entry valid.
REQ-011 The block SHALL have port m_ready  input  1  downstream accepts the entry.
REQ-012 The block SHALL have port m_data  output  DATA_WIDTH  output payload.
REQ-013 The block SHALL have port m_tag  output  TAG_WIDTH  flux index of the output payload.
REQ-014 The block SHALL have port tag_err  output  1  sticky tag-mismatch flag (macro-dependent, REQ-031).

Function
REQ-015 A flux SHALL be eligible when fifo_empty[i]==0 and flux_en[i]==1.
REQ-016 slot_free SHALL be (m_valid==0) or (m_ready==1).
REQ-017 fifo_read SHALL be zero unless slot_free and at least one flux is eligible; then exactly one bit SHALL be set, for the granted flux.
REQ-018 The grant SHALL be round-robin: search starts at (last_grant+1) mod FLUX, increments with wrap from FLUX-1 to 0, and picks the first eligible flux.
REQ-019 last_grant SHALL update to the granted index on every edge where fifo_read is non-zero, and hold otherwise.
REQ-020 fifo_read SHALL be combinational from current state and inputs, with no latency to the FIFO.
REQ-021 On an edge with fifo_read non-zero, m_data SHALL load fifo_dout[DATA_WIDTH-1:0], m_tag SHALL load the granted index (not the FIFO tag field), and m_valid SHALL be set: one-cycle latency from grant to m_valid.
REQ-022 On an edge with m_valid&m_ready and no grant, m_valid SHALL clear; m_data/m_tag SHALL hold.
REQ-023 Simultaneous accept and grant SHALL keep m_valid=1 with the new entry, sustaining one entry per cycle.
REQ-024 While m_valid=1 and m_ready=0, m_data, m_tag and m_valid SHALL hold stable and fifo_read SHALL be zero.
REQ-025 A flux whose flux_en drops SHALL not be granted from the next evaluation; an entry already in the output register SHALL be unaffected.
REQ-026 With no flux eligible, fifo_read=0 and last_grant SHALL hold.
REQ-027 The block SHALL never assert fifo_read for a flux whose fifo_empty is 1.

Reset
REQ-028 While rst=1 on an edge: m_valid=0, m_data=0, m_tag=0, tag_err=0, and last_grant=FLUX-1 so flux 0 has first priority.
REQ-029 fifo_read SHALL be forced to 0 in every cycle rst=1, including mid-transfer; a held output entry SHALL be discarded.

Configuration
REQ-030 The macro FIFO_RD_ARB_TAG_CHECK_EN SHALL control tag checking.
REQ-031 With FIFO_RD_ARB_TAG_CHECK_EN defined, on each grant edge where fifo_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH] differs from the granted index, tag_err SHALL set and SHALL stay set until rst.
REQ-032 Without FIFO_RD_ARB_TAG_CHECK_EN, tag_err SHALL be tied to 0 and no comparator logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-033 Reset then FLUX=2, fifo_empty=2'b00, flux_en=2'b11, m_ready=1 for 4 cycles -> fifo_read 01,10,01,10; m_tag 0,1,0,1 one cycle later; m_valid continuous.
REQ-034 m_valid=1, m_ready=0 for 3 cycles with both fluxes non-empty -> fifo_read=00, m_data/m_tag stable; m_ready=1 -> grant resumes the same cycle, next flux in RR order.
REQ-035 fifo_empty=2'b10, flux_en=2'b11 for 3 cycles -> fifo_read=01 every slot_free cycle; flux_en=2'b10 -> fifo_read=00, m_valid clears after accept.
REQ-036 FLUX=4, last_grant=3, only flux 3 eligible -> wrap search grants flux 3 (fifo_read=4'b1000), m_tag=3.
REQ-037 rst asserted with m_valid=1, m_ready=0 -> next edge m_valid=0, tag_err=0; first grant after release is flux 0.
REQ-038 With FIFO_RD_ARB_TAG_CHECK_EN: grant flux 1 while fifo_dout tag=0 -> tag_err=1 next cycle and sticky; without macro, tag_err=0.

Source files
------------

// File: rtl/fifo_rd_arb.sv
// Round-robin read arbiter for a shared multi-flux FIFO with a one-entry output register.
// Optional tag checking of FIFO read data is enabled by defining FIFO_RD_ARB_TAG_CHECK_EN.
module fifo_rd_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  localparam int TAG_WIDTH = $clog2(FLUX)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FLUX-1:0]                 fifo_empty,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_dout,
  output logic [FLUX-1:0]                 fifo_read,
  input  logic [FLUX-1:0]                 flux_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [TAG_WIDTH-1:0]            m_tag,
  output logic                            tag_err
);

  logic [FLUX-1:0]      eligible;
  logic                 slot_free;
  logic [TAG_WIDTH-1:0] last_grant;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic                 grant_vld;
  logic                 grant;
  logic [TAG_WIDTH:0]   probe;

  assign eligible  = ~fifo_empty & flux_en;
  assign slot_free = ~m_valid | m_ready;

  // Search starts one past the last winner; the extra probe bit makes the
  // wrap correct for non-power-of-two FLUX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_idx = '0;
    grant_vld = 1'b0;
    probe     = '0;
    for (int k = 1; k <= FLUX; k++) begin
      probe = {1'b0, last_grant} + (TAG_WIDTH+1)'(k);
      if (probe >= (TAG_WIDTH+1)'(FLUX))
        probe = probe - (TAG_WIDTH+1)'(FLUX);
      if (!grant_vld && eligible[probe[TAG_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = probe[TAG_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    fifo_read = '0;
    if (!rst && slot_free && grant_vld)
      fifo_read[grant_idx] = 1'b1;
  end

  assign grant = |fifo_read;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_tag      <= '0;
      last_grant <= TAG_WIDTH'(FLUX-1);
    end else if (grant) begin
      m_valid    <= 1'b1;
      m_data     <= fifo_dout[DATA_WIDTH-1:0];
      m_tag      <= grant_idx;
      last_grant <= grant_idx;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_ARB_TAG_CHECK_EN
  logic tag_err_q;

  always_ff @(posedge clk) begin
    if (rst)
      tag_err_q <= 1'b0;
    else if (grant && (fifo_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH] != grant_idx))
      tag_err_q <= 1'b1;
  end

  assign tag_err = tag_err_q;
`else
  // The FIFO tag field is deliberately ignored when checking is compiled out.
  logic unused_tag;
  assign unused_tag = ^fifo_dout[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign tag_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Self-checking bench for fifo_rd_arb: a FLUX=2 and a FLUX=4 instance run side by side
// against a behavioural model; directed scenarios followed by randomized traffic.
module tb_fifo_rd_arb;

  logic clk = 1'b0;
  logic rst;
  logic bad_tag;

  logic [1:0] empty_a, en_a, read_a;
  logic       ready_a, valid_a, err_a;
  logic [7:0] data_a;
  logic [0:0] tag_a;
  logic [8:0] dout_a;
  logic [7:0] pay_a [2];

  logic [3:0] empty_b, en_b, read_b;
  logic       ready_b, valid_b, err_b;
  logic [7:0] data_b;
  logic [1:0] tag_b;
  logic [9:0] dout_b;
  logic [7:0] pay_b [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance (0: FLUX=2, 1: FLUX=4)
  int m_last [2];
  bit m_vld  [2];
  int m_dat  [2];
  int m_tg   [2];
  bit m_err  [2];

  always #5 clk = ~clk;

  fifo_rd_arb #(.DATA_WIDTH(8), .FLUX(2)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_dout(dout_a), .fifo_read(read_a),
    .flux_en(en_a), .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a), .m_tag(tag_a),
    .tag_err(err_a)
  );

  fifo_rd_arb #(.DATA_WIDTH(8), .FLUX(4)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_dout(dout_b), .fifo_read(read_b),
    .flux_en(en_b), .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b), .m_tag(tag_b),
    .tag_err(err_b)
  );

  // FIFO read data follows the strobe combinationally; bad_tag zeroes the tag field.
  always_comb begin
    dout_a = '0;
    for (int i = 0; i < 2; i++)
      if (read_a[i]) dout_a = {(bad_tag ? 1'b0 : 1'(i)), pay_a[i]};
  end

  always_comb begin
    dout_b = '0;
    for (int i = 0; i < 4; i++)
      if (read_b[i]) dout_b = {(bad_tag ? 2'b0 : 2'(i)), pay_b[i]};
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // First eligible flux in round-robin order after 'last', or -1 when nothing may be read.
  function automatic int model_grant(int n, int last, int empty, int en, bit vld, bit rdy);
    if (vld && !rdy) return -1;
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if ((((empty >> i) & 1) == 0) && (((en >> i) & 1) == 1)) return i;
    end
    return -1;
  endfunction

  function automatic int pay_of(int u, int i);
    return (u == 0) ? int'(pay_a[i]) : int'(pay_b[i]);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_last[u] = (u == 0) ? 1 : 3;
      m_vld[u]  = 1'b0;
      m_dat[u]  = 0;
      m_tg[u]   = 0;
      m_err[u]  = 1'b0;
    end
  endtask

  // One clock: check the read strobe mid-cycle, then the registered outputs just after the edge.
  task automatic step();
    int g [2];
    for (int i = 0; i < 2; i++) pay_a[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) pay_b[i] = 8'($urandom);
    @(negedge clk);
    g[0] = rst ? -1 : model_grant(2, m_last[0], int'(empty_a), int'(en_a), m_vld[0], ready_a);
    g[1] = rst ? -1 : model_grant(4, m_last[1], int'(empty_b), int'(en_b), m_vld[1], ready_b);
    check("read_a", int'(read_a), (g[0] < 0) ? 0 : (1 << g[0]));
    check("read_b", int'(read_b), (g[1] < 0) ? 0 : (1 << g[1]));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (g[u] >= 0) begin
          m_vld[u]  = 1'b1;
          m_dat[u]  = pay_of(u, g[u]);
          m_tg[u]   = g[u];
          m_last[u] = g[u];
`ifdef FIFO_RD_ARB_TAG_CHECK_EN
          if (bad_tag && g[u] != 0) m_err[u] = 1'b1;
`endif
        end else if ((u == 0) ? ready_a : ready_b) begin
          m_vld[u] = 1'b0;
        end
      end
    end
    #1;
    check("valid_a", int'(valid_a), int'(m_vld[0]));
    check("data_a",  int'(data_a),  m_dat[0]);
    check("tag_a",   int'(tag_a),   m_tg[0]);
    check("err_a",   int'(err_a),   int'(m_err[0]));
    check("valid_b", int'(valid_b), int'(m_vld[1]));
    check("data_b",  int'(data_b),  m_dat[1]);
    check("tag_b",   int'(tag_b),   m_tg[1]);
    check("err_b",   int'(err_b),   int'(m_err[1]));
  endtask

  initial begin
    model_reset();
    rst = 1'b1; bad_tag = 1'b0;
    empty_a = 2'b00; en_a = 2'b11; ready_a = 1'b1;
    empty_b = 4'b0000; en_b = 4'b1111; ready_b = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Full-rate alternation on both fluxes, continuous valid
    repeat (4) step();

    // Back-pressure holds the entry, then grant resumes in RR order
    ready_a = 1'b0; ready_b = 1'b0;
    repeat (3) step();
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (2) step();

    // Only flux 0 has data; then it is masked off and valid drains
    empty_a = 2'b10;
    repeat (3) step();
    en_a = 2'b10;
    repeat (2) step();

    // FLUX=4: only flux 3 eligible, twice, so the second search wraps from last_grant=3
    empty_b = 4'b0111;
    repeat (2) step();

    // Corrupt tag on a flux-1 grant; the flag must remain set afterwards
    en_a = 2'b11; empty_a = 2'b01; empty_b = 4'b1101; bad_tag = 1'b1;
    step();
    bad_tag = 1'b0; empty_a = 2'b00; empty_b = 4'b0000;
    repeat (2) step();

    // Reset while an entry is stalled, then flux 0 wins first
    ready_a = 1'b0; ready_b = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    repeat (2) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      empty_a = 2'($urandom); en_a = 2'($urandom); ready_a = 1'($urandom_range(0, 3) != 0);
      empty_b = 4'($urandom); en_b = 4'($urandom); ready_b = 1'($urandom_range(0, 3) != 0);
      bad_tag = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
